// File: rtl/mem_dados.sv
// ============================================================================
//  Module   : mem_dados
//  Purpose  : Data-memory responder for the nRisc load/store side. Stores are
//             posted into a DEPTH-entry FIFO write buffer and drained into a
//             256x8 RAM that needs WRITE_CYCLES cycles per write. Loads get a
//             one-cycle registered response, forwarded from the newest
//             pending buffered write to the same address when one exists.
//  Revision : 1.0 - initial release
//
//  Ports
//    Clock      in   1  system clock, rising edge
//    Reset      in   1  asynchronous, active-high reset
//    LerMem     in   1  read request
//    EscrevMem  in   1  write request
//    Endereco   in   8  byte address
//    DadoEscr   in   8  write data
//    DadoLido   out  8  read data (holds when no read)
//    DadoValido out  1  DadoLido refreshed by a read on the last edge
//    Ocupado    out  1  write buffer full
//    Erro       out  1  sticky dropped-write flag
//
//  Build option
//    MEMDADOS_ERRO_EN : when defined, Erro latches high on any dropped write
//                       until Reset; when undefined, Erro is tied low.
// ============================================================================
`default_nettype none

module mem_dados #(
  parameter int DEPTH        = 4,
  parameter int WRITE_CYCLES = 3
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       LerMem,
  input  logic       EscrevMem,
  input  logic [7:0] Endereco,
  input  logic [7:0] DadoEscr,
  output logic [7:0] DadoLido,
  output logic       DadoValido,
  output logic       Ocupado,
  output logic       Erro
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WRITE_CYCLES + 1);

  localparam logic [AW:0]   C_DEPTH = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] C_WC    = CW'(WRITE_CYCLES);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  // Drain FSM encoding
  localparam logic [0:0] OCIOSO   = 1'b0;
  localparam logic [0:0] GRAVANDO = 1'b1;

  // Storage (never reset)
  logic [7:0] fifo_addr_q [DEPTH];
  logic [7:0] fifo_data_q [DEPTH];
  logic [7:0] mem_q       [256];

  // Control state
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic [0:0]    state_q,  state_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [7:0]    dado_lido_q, dado_lido_d;
  logic          dado_valido_q;

  logic          w_commit;
  logic          w_push;
  logic          w_fwd_hit;
  logic [7:0]    w_fwd_data;
  logic [AW-1:0] w_fwd_idx;

  // The head is committed on the last cycle of its RAM write.
  assign w_commit = (state_q == GRAVANDO) && (cnt_q == C_WC);

  // A full buffer still accepts a write when the head leaves on the same edge.
  assign w_push   = EscrevMem && ((count_q != C_DEPTH) || w_commit);

  assign Ocupado  = (count_q == C_DEPTH);

  // ---------------------------------------------------------------------------
  // Drain FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      OCIOSO: begin
        if (count_q != '0) begin
          state_d = GRAVANDO;
          cnt_d   = C_ONE;
        end
      end
      GRAVANDO: begin
        if (w_commit) begin
          state_d = OCIOSO;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + C_ONE;
        end
      end
      default: begin
        state_d = OCIOSO;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = w_push   ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = w_commit ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({w_push, w_commit})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read forwarding: scan entries oldest to newest so the newest match wins.
  // Only entries already in the buffer are searched, so a same-cycle write
  // never affects the value returned by a simultaneous read.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = 8'h00;
    w_fwd_idx  = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      w_fwd_idx = rd_ptr_q + AW'(i);
      if (((AW + 1)'(i) < count_q) && (fifo_addr_q[w_fwd_idx] == Endereco)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = fifo_data_q[w_fwd_idx];
      end
    end
  end

  always_comb begin
    dado_lido_d = dado_lido_q;
    if (LerMem) begin
      dado_lido_d = w_fwd_hit ? w_fwd_data : mem_q[Endereco];
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= OCIOSO;
      cnt_q         <= '0;
      dado_lido_q   <= 8'h00;
      dado_valido_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dado_lido_q   <= dado_lido_d;
      dado_valido_q <= LerMem;
    end
  end

  // ---------------------------------------------------------------------------
  // Buffer and RAM arrays. A commit cannot occur while Reset is high because
  // the FSM is held in OCIOSO, so an interrupted write never reaches RAM.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (w_push) begin
      fifo_addr_q[wr_ptr_q] <= Endereco;
      fifo_data_q[wr_ptr_q] <= DadoEscr;
    end
    if (w_commit) begin
      mem_q[fifo_addr_q[rd_ptr_q]] <= fifo_data_q[rd_ptr_q];
    end
  end

  assign DadoLido   = dado_lido_q;
  assign DadoValido = dado_valido_q;

`ifdef MEMDADOS_ERRO_EN
  logic w_drop;
  logic erro_q;

  assign w_drop = EscrevMem && !w_push;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      erro_q <= 1'b0;
    end else if (w_drop) begin
      erro_q <= 1'b1;
    end
  end

  assign Erro = erro_q;
`else
  assign Erro = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_dados.sv
// ============================================================================
//  Module   : tb_mem_dados
//  Purpose  : Self-checking bench for mem_dados (DEPTH=4, WRITE_CYCLES=8).
//             Reads push their expected data and response cycle into a
//             scoreboard queue; a monitor pops and compares whenever the DUT
//             raises DadoValido. Status outputs are checked directly.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_dados;

  localparam int DEPTH = 4;
  localparam int WC    = 8;
  localparam int ENTRY = WC + 1;

`ifdef MEMDADOS_ERRO_EN
  localparam logic ERRO_EN = 1'b1;
`else
  localparam logic ERRO_EN = 1'b0;
`endif

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       LerMem = 1'b0;
  logic       EscrevMem = 1'b0;
  logic [7:0] Endereco = 8'h00;
  logic [7:0] DadoEscr = 8'h00;
  logic [7:0] DadoLido;
  logic       DadoValido;
  logic       Ocupado;
  logic       Erro;

  mem_dados #(.DEPTH(DEPTH), .WRITE_CYCLES(WC)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .LerMem     (LerMem),
    .EscrevMem  (EscrevMem),
    .Endereco   (Endereco),
    .DadoEscr   (DadoEscr),
    .DadoLido   (DadoLido),
    .DadoValido (DadoValido),
    .Ocupado    (Ocupado),
    .Erro       (Erro)
  );

  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t sb[$];

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // Monitor: compares each read response against the scoreboard head.
  always @(negedge Clock) begin
    exp_t e;
    if (!Reset) begin
      if (DadoValido) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid: DadoLido=0x%02h with no read pending", DadoLido);
        end else begin
          e = sb.pop_front();
          if (DadoLido !== e.data || cyc != e.at) begin
            failures++;
            $display("FAIL read_data: got 0x%02h at cycle %0d expected 0x%02h at cycle %0d",
                     DadoLido, cyc, e.data, e.at);
          end
        end
      end else if (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_valid: no response at cycle %0d expected 0x%02h", cyc, e.data);
      end
    end
  end

  task automatic idle(input int n);
    LerMem    = 1'b0;
    EscrevMem = 1'b0;
    repeat (n) @(negedge Clock);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    LerMem    = 1'b0;
    EscrevMem = 1'b1;
    Endereco  = a;
    DadoEscr  = d;
    @(negedge Clock);
    EscrevMem = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] e);
    exp_t x;
    LerMem    = 1'b1;
    EscrevMem = 1'b0;
    Endereco  = a;
    x.data    = e;
    x.at      = cyc + 1;
    sb.push_back(x);
    @(negedge Clock);
    LerMem    = 1'b0;
  endtask

  task automatic rdwr(input logic [7:0] a, input logic [7:0] d, input logic [7:0] e);
    exp_t x;
    LerMem    = 1'b1;
    EscrevMem = 1'b1;
    Endereco  = a;
    DadoEscr  = d;
    x.data    = e;
    x.at      = cyc + 1;
    sb.push_back(x);
    @(negedge Clock);
    LerMem    = 1'b0;
    EscrevMem = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge Clock);
    chk("reset_DadoLido",   DadoLido,         8'h00);
    chk("reset_DadoValido", {7'd0, DadoValido}, 8'h00);
    chk("reset_Ocupado",    {7'd0, Ocupado},    8'h00);
    chk("reset_Erro",       {7'd0, Erro},       8'h00);
    Reset = 1'b0;
    @(negedge Clock);

    // Forwarding of a just-posted write
    wr(8'h10, 8'hA5);
    rd(8'h10, 8'hA5);

    // Newest of two same-address entries wins; later served from RAM
    wr(8'h20, 8'h11);
    wr(8'h20, 8'h22);
    rd(8'h20, 8'h22);
    idle(4 * ENTRY);
    rd(8'h20, 8'h22);
    chk("drained_Ocupado", {7'd0, Ocupado}, 8'h00);

    // Fill the buffer; fifth write is dropped
    wr(8'h54, 8'hEE);
    idle(2 * ENTRY);
    wr(8'h50, 8'h60);
    wr(8'h51, 8'h61);
    wr(8'h52, 8'h62);
    wr(8'h53, 8'h63);
    chk("full_Ocupado", {7'd0, Ocupado}, 8'h01);
    chk("prefull_Erro", {7'd0, Erro},    8'h00);
    wr(8'h54, 8'h99);
    chk("drop_Ocupado", {7'd0, Ocupado}, 8'h01);
    chk("drop_Erro",    {7'd0, Erro},    {7'd0, ERRO_EN});
    rd(8'h50, 8'h60);
    rd(8'h51, 8'h61);
    rd(8'h52, 8'h62);
    rd(8'h53, 8'h63);
    rd(8'h54, 8'hEE);
    idle(5 * ENTRY);
    chk("afterdrain_Ocupado", {7'd0, Ocupado}, 8'h00);
    rd(8'h50, 8'h60);
    rd(8'h51, 8'h61);
    rd(8'h52, 8'h62);
    rd(8'h53, 8'h63);
    rd(8'h54, 8'hEE);

    // Simultaneous read and write return the old value
    wr(8'h30, 8'h01);
    idle(2 * ENTRY);
    rdwr(8'h30, 8'h02, 8'h01);
    rd(8'h30, 8'h02);
    idle(2 * ENTRY);
    rd(8'h30, 8'h02);

    // Reset during an in-flight write abandons it
    wr(8'h40, 8'h33);
    idle(2 * ENTRY);
    wr(8'h40, 8'h77);
    idle(3);
    #1 Reset = 1'b1;
    #2 Reset = 1'b0;
    @(negedge Clock);
    chk("midreset_DadoLido", DadoLido,         8'h00);
    chk("midreset_Ocupado",  {7'd0, Ocupado},    8'h00);
    chk("midreset_Erro",     {7'd0, Erro},       8'h00);
    rd(8'h40, 8'h33);
    idle(2 * ENTRY);
    rd(8'h40, 8'h33);

    // Idle: valid drops, data holds
    idle(3);
    chk("idle_DadoValido", {7'd0, DadoValido}, 8'h00);
    chk("idle_DadoLido",   DadoLido,           8'h33);

    idle(3);
    chk("scoreboard_empty", 8'(sb.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
